cnt2_seq_monitor: RTL
=====================

// Module: cnt2_seq_monitor
// PURPOSE
//   Downstream checker for the 2-bit down-counter stage (sequence 00->11->10->01->00).
//   Samples the counter output and confirms that each enabled sample is the previous value minus 1, mod 4.
//   Reports lock status, a sticky sequence error, a one-cycle pulse per wrap, and a saturating wrap count.
//   Drives status/interrupt logic; purely an observer, never drives the counter.
// PARAMETERS
//   CNT_W        8   width of wrap_count (saturating)
//   LOCK_CYCLES  2   consecutive correct transitions needed to go SYNC->LOCKED (>=1)
// PORTS
//   clk         in   1      rising-edge clock, shared with counter stage
//   rst         in   1      asynchronous, active-high reset
//   cnt_in      in   2      counter value from upstream stage (q[1:0])
//   en          in   1      sample enable; cnt_in checked only on edges with en=1
//   clr_err     in   1      leaves FAULT, clears seq_err (level, sampled on clk)
//   locked      out  1      1 while in LOCKED
//   seq_err     out  1      sticky: set on entry to FAULT
//   wrap_pulse  out  1      one-cycle pulse per counted wrap
//   wrap_count  out  CNT_W  number of wraps seen while LOCKED, saturates at 2^CNT_W-1
// BEHAVIOUR
//   - All outputs registered; the response to a sample taken at edge k appears right after edge k.
//   - rst=1 (async, no clock needed): state=IDLE, prev=0, match_cnt=0.
//     Also on reset: locked=0, seq_err=0, wrap_pulse=0, wrap_count=0.
//   - "correct" means cnt_in == (prev - 2'd1) mod 4. An unchanged value counts as incorrect.
//   - On every edge with en=1 (except an edge where FAULT is left), prev <= cnt_in.
//   - "wrap" means prev==2'b00 and cnt_in==2'b11.
//   - en=0: no check; state, prev, match_cnt and wrap_count hold; wrap_pulse=0.
//   - FSM, 2-bit state:
//       IDLE   : en=1 -> capture prev, match_cnt=0, go SYNC.
//       SYNC   : correct -> match_cnt+1; go LOCKED on reaching LOCK_CYCLES (locked=1 after that edge).
//                incorrect -> match_cnt=0, stay. Wraps are not counted in SYNC.
//       LOCKED : correct -> stay; on a wrap: wrap_pulse=1 for one cycle and wrap_count+1 (saturating).
//                incorrect -> FAULT; seq_err=1, locked=0, no pulse.
//       FAULT  : ignores cnt_in; clr_err=1 -> IDLE, seq_err=0, sample on that edge discarded.
//   - clr_err outside FAULT has no effect. clr_err and en together in FAULT: clr_err wins.
//   - wrap_count is never cleared except by rst; it holds through FAULT/IDLE/SYNC.
//   - At saturation: wrap_pulse still fires and wrap_count stays at 2^CNT_W-1 (no roll-over).
//   - Reset asserted mid-operation forces the reset values immediately; the next sample after release starts from IDLE.
// TESTING
//   1 Reset, en=1, cnt_in 00,11,10,01,00,11 on successive edges -> locked=1 after the 3rd sample edge.
//     Then wrap_pulse=1 for exactly one cycle after the 6th edge, wrap_count=1, seq_err=0.
//   2 CNT_W=2, locked, run 5 full wraps -> wrap_pulse 5 times, wrap_count 1,2,3,3,3.
//   3 Locked at prev=10, feed 00 (skip) -> seq_err=1, locked=0 after that edge, wrap_count unchanged.
//     Then clr_err=1 for one edge -> seq_err=0, state IDLE, relock after LOCK_CYCLES correct transitions.
//   4 SYNC with match_cnt=1, feed a repeated value -> no lock, match_cnt restarts.
//     Lock then needs 2 further correct transitions.
//   5 Locked, en=0 for 3 cycles while cnt_in stays 10, then en=1 with 01 -> no error, locked stays 1, no wrap_pulse.
//   6 Locked with wrap_count=4, assert rst between clock edges -> all outputs 0 before the next edge.
//     After rst release, no lock until the IDLE->SYNC->LOCKED sequence completes.

Source files
------------

// File: rtl/cnt2_seq_monitor_if.sv
// Observation bus between the 2-bit down-counter stage and its sequence monitor.
// The master side supplies samples and controls; the slave (monitor) reports status.
interface cnt2_seq_monitor_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       cnt_in;
  logic             en;
  logic             clr_err;
  logic             locked;
  logic             seq_err;
  logic             wrap_pulse;
  logic [CNT_W-1:0] wrap_count;

  modport master (
    output cnt_in, en, clr_err,
    input  locked, seq_err, wrap_pulse, wrap_count
  );

  modport slave (
    input  cnt_in, en, clr_err,
    output locked, seq_err, wrap_pulse, wrap_count
  );
endinterface

// File: rtl/cnt2_seq_monitor.sv
// Observer for the 2-bit down-counter: checks each enabled sample is prev-1 mod 4,
// tracks lock, latches a sticky sequence error and counts wraps seen while locked.
module cnt2_seq_monitor #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  cnt2_seq_monitor_if.slave  mon
);
  localparam int MW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       prev;
  logic [MW-1:0]    match_cnt;
  logic             locked_q;
  logic             seq_err_q;
  logic             wrap_pulse_q;
  logic [CNT_W-1:0] wrap_count_q;

  logic          correct;
  logic          wrap;
  logic [MW-1:0] match_next;

  // NOTE: purely combinational decode; every signal is assigned on every path, so no latch.
  always_comb begin
    correct    = (mon.cnt_in == (prev - 2'd1));
    wrap       = (prev == 2'b00) && (mon.cnt_in == 2'b11);
    match_next = match_cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      prev         <= 2'b00;
      match_cnt    <= '0;
      locked_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      wrap_pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mon.en) begin
            prev      <= mon.cnt_in;
            match_cnt <= '0;
            state     <= SYNC;
          end
        end
        SYNC: begin
          if (mon.en) begin
            prev <= mon.cnt_in;
            if (correct) begin
              match_cnt <= match_next;
              if (match_next == MW'(LOCK_CYCLES)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (mon.en) begin
            prev <= mon.cnt_in;
            if (!correct) begin
              state     <= FAULT;
              locked_q  <= 1'b0;
              seq_err_q <= 1'b1;
            end else if (wrap) begin
              wrap_pulse_q <= 1'b1;
              // Saturate rather than roll over so status software never sees a false small count.
              if (wrap_count_q != '1) wrap_count_q <= wrap_count_q + 1'b1;
            end
          end
        end
        FAULT: begin
          // clr_err takes priority and the sample on the clearing edge is dropped.
          if (mon.clr_err) begin
            state     <= IDLE;
            seq_err_q <= 1'b0;
          end else if (mon.en) begin
            prev <= mon.cnt_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mon.locked     = locked_q;
  assign mon.seq_err    = seq_err_q;
  assign mon.wrap_pulse = wrap_pulse_q;
  assign mon.wrap_count = wrap_count_q;
endmodule
